// File: rtl/core_input_fifo_pkg.sv
// Shared IO-path package: word width, default input FIFO depth and the
// request-FSM state encoding used by the core input FIFO.
package core_input_fifo_pkg;

  localparam int unsigned IO_WORD_W     = 32;
  localparam int unsigned IO_FIFO_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the input FIFO: one write port and one
// synchronous read port (read-first), shaped to map onto block RAM.
module fifo_mem
  import core_input_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = IO_FIFO_DEPTH,
  parameter int unsigned WIDTH = IO_WORD_W,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write and registered read; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/core_input_fifo.sv
// Input FIFO between the UART receive path and the core's input instruction,
// with an empty-FIFO wait state that bypasses the next received word.
module core_input_fifo
  import core_input_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = IO_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IO_WORD_W-1:0] wd,
  input  logic                 req,
  output logic [IO_WORD_W-1:0] input_data,
  output logic                 input_data_ready,
  output logic                 empty,
  output logic                 full,
  output logic [AW:0]          count,
  output logic                 overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fifo_state_e          state_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW-1:0]        wr_ptr_q;
  logic [AW:0]          count_q;
  logic [IO_WORD_W-1:0] data_q;
  logic                 ready_q;
  logic                 overflow_q;

  logic                 pop_s;
  logic                 bypass_s;
  logic                 push_s;
  logic                 drop_s;
  logic [IO_WORD_W-1:0] mem_rdata_s;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Decode this cycle's pop / bypass / store / drop from state and inputs.
  // WAIT also pops if a word was stored in the same cycle the request arrived.
  always_comb begin
    pop_s    = 1'b0;
    bypass_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !empty) pop_s = 1'b1;
        else               pop_s = 1'b0;
      end
      ST_WAIT: begin
        if (!empty)  pop_s    = 1'b1;
        else if (we) bypass_s = 1'b1;
        else         bypass_s = 1'b0;
      end
      default: begin
        pop_s    = 1'b0;
        bypass_s = 1'b0;
      end
    endcase
    push_s = we && !bypass_s && (!full || pop_s);
    drop_s = we && !bypass_s && full && !pop_s;
  end

  // Request FSM, pointers, occupancy and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req) state_q <= empty ? ST_WAIT : ST_RESP;
        ST_WAIT: begin
          if (pop_s)         state_q <= ST_RESP;
          else if (bypass_s) state_q <= ST_IDLE;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);

      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase

      if (drop_s) overflow_q <= 1'b1;

      ready_q <= pop_s || bypass_s;

      // Keep the last returned word so input_data holds between responses.
      if (bypass_s)                data_q <= wd;
      else if (state_q == ST_RESP) data_q <= mem_rdata_s;
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (IO_WORD_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wd),
    .re_i    (pop_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata_s)
  );

  assign input_data       = (state_q == ST_RESP) ? mem_rdata_s : data_q;
  assign input_data_ready = ready_q;
  assign count            = count_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_core_input_fifo.sv
// Self-checking bench for core_input_fifo (DEPTH=4): directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_core_input_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] wd;
  logic        req;
  logic [31:0] input_data;
  logic        input_data_ready;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  core_input_fifo #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .we               (we),
    .wd               (wd),
    .req              (req),
    .input_data       (input_data),
    .input_data_ready (input_data_ready),
    .empty            (empty),
    .full             (full),
    .count            (count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; we = 1'b0; req = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] d);
    we = 1'b1; wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic do_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; wd = 32'hFFFF_FFFF; req = 1'b1;
    tick(); tick();
    checks++; if (input_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 00000000", input_data); end
    checks++; if (input_data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", input_data_ready); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0; we = 1'b0; req = 1'b0;
    tick();
  endtask

  task automatic test_order();
    logic [31:0] w [3];
    w[0] = 32'h1111_1111; w[1] = 32'h2222_2222; w[2] = 32'h3333_3333;
    apply_reset();
    for (int i = 0; i < 3; i++) do_write(w[i]);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL order_count_filled: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      do_req();
      checks++; if (input_data_ready !== 1'b1) begin failures++; $display("FAIL order_ready[%0d]: got %b want 1", i, input_data_ready); end
      checks++; if (input_data !== w[i]) begin failures++; $display("FAIL order_data[%0d]: got %h want %h", i, input_data, w[i]); end
      checks++; if (count !== 3'(2 - i)) begin failures++; $display("FAIL order_count[%0d]: got %0d want %0d", i, count, 2 - i); end
      for (int k = 0; k < 3; k++) begin
        tick();
        checks++; if (input_data_ready !== 1'b0) begin failures++; $display("FAIL order_pulse_width[%0d]: got %b want 0", i, input_data_ready); end
        checks++; if (input_data !== w[i]) begin failures++; $display("FAIL order_hold[%0d]: got %h want %h", i, input_data, w[i]); end
      end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL order_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_wait_bypass();
    apply_reset();
    do_req();
    for (int k = 0; k < 10; k++) begin
      req = (k == 4);
      checks++; if (input_data_ready !== 1'b0) begin failures++; $display("FAIL wait_no_ready[%0d]: got %b want 0", k, input_data_ready); end
      tick();
    end
    req = 1'b0;
    do_write(32'hDEAD_BEEF);
    checks++; if (input_data_ready !== 1'b1) begin failures++; $display("FAIL bypass_ready: got %b want 1", input_data_ready); end
    checks++; if (input_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_data: got %h want deadbeef", input_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL bypass_count: got %0d want 0", count); end
    tick();
    checks++; if (input_data_ready !== 1'b0) begin failures++; $display("FAIL bypass_single_pulse: got %b want 0", input_data_ready); end
    checks++; if (input_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_hold: got %h want deadbeef", input_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL bypass_count_after: got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_write(32'(i));
      if (i == 3) begin
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full_after4: got %b want 1", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", overflow); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count: got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      do_req();
      checks++; if (input_data_ready !== 1'b1) begin failures++; $display("FAIL ovf_drain_ready[%0d]: got %b want 1", i, input_data_ready); end
      checks++; if (input_data !== 32'(i)) begin failures++; $display("FAIL ovf_drain_data[%0d]: got %h want %h", i, input_data, 32'(i)); end
      tick();
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_simul_full();
    logic [31:0] exp [4];
    apply_reset();
    for (int i = 0; i < 4; i++) do_write(32'h100 + 32'(i));
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL simul_full_before: got %b want 1", full); end
    req = 1'b1; we = 1'b1; wd = 32'hA5A5_A5A5;
    tick();
    req = 1'b0; we = 1'b0;
    checks++; if (input_data !== 32'h100) begin failures++; $display("FAIL simul_pop_data: got %h want 00000100", input_data); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL simul_count: got %0d want 4", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL simul_overflow: got %b want 0", overflow); end
    tick();
    exp[0] = 32'h101; exp[1] = 32'h102; exp[2] = 32'h103; exp[3] = 32'hA5A5_A5A5;
    for (int i = 0; i < 4; i++) begin
      do_req();
      checks++; if (input_data_ready !== 1'b1 || input_data !== exp[i]) begin failures++; $display("FAIL simul_drain[%0d]: got rdy=%b %h want rdy=1 %h", i, input_data_ready, input_data, exp[i]); end
      tick();
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL simul_overflow_end: got %b want 0", overflow); end
  endtask

  task automatic test_wrap();
    logic [31:0] wr_val;
    logic [31:0] rd_val;
    wr_val = 32'h1000;
    rd_val = 32'h1000;
    apply_reset();
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 3; i++) begin
        do_write(wr_val);
        wr_val = wr_val + 32'd1;
      end
      for (int i = 0; i < 3; i++) begin
        do_req();
        checks++; if (input_data_ready !== 1'b1 || input_data !== rd_val) begin failures++; $display("FAIL wrap[%0d.%0d]: got rdy=%b %h want rdy=1 %h", r, i, input_data_ready, input_data, rd_val); end
        rd_val = rd_val + 32'd1;
        tick();
      end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    do_req();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (input_data_ready !== 1'b0) begin failures++; $display("FAIL rstwait_ready_rst: got %b want 0", input_data_ready); end
    do_write(32'h5);
    checks++; if (input_data_ready !== 1'b0) begin failures++; $display("FAIL rstwait_no_bypass: got %b want 0", input_data_ready); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL rstwait_count: got %0d want 1", count); end
    tick();
    checks++; if (input_data_ready !== 1'b0) begin failures++; $display("FAIL rstwait_late_ready: got %b want 0", input_data_ready); end
    do_req();
    checks++; if (input_data_ready !== 1'b1 || input_data !== 32'h5) begin failures++; $display("FAIL rstwait_req: got rdy=%b %h want rdy=1 00000005", input_data_ready, input_data); end
  endtask

  // Reference: a word queue plus an outstanding-request flag. A request is
  // served from the queue head, or by the next write if the queue is empty;
  // requests are ignored while one is outstanding or being answered.
  task automatic test_random(input int we_pct, input int req_pct, input int cycles);
    logic [31:0] q [$];
    logic [31:0] exp_data;
    logic [31:0] nxt_data;
    bit pending;
    bit answering;
    bit exp_ovf;
    bit nxt_ready;
    bit popped;
    bit bypassed;
    int sz0;
    apply_reset();
    exp_data = 32'h0; pending = 0; answering = 0; exp_ovf = 0; nxt_data = 32'h0;
    for (int c = 0; c < cycles; c++) begin
      we  = ($urandom_range(99) < we_pct);
      req = ($urandom_range(99) < req_pct);
      wd  = $urandom;
      sz0 = q.size();
      nxt_ready = 0; popped = 0; bypassed = 0;
      if (pending) begin
        if (sz0 > 0) begin
          nxt_data = q.pop_front(); popped = 1; pending = 0; nxt_ready = 1;
        end else if (we) begin
          nxt_data = wd; bypassed = 1; pending = 0; nxt_ready = 1;
        end
      end else if (req && !answering) begin
        if (sz0 > 0) begin
          nxt_data = q.pop_front(); popped = 1; nxt_ready = 1;
        end else begin
          pending = 1;
        end
      end
      if (we && !bypassed) begin
        if (sz0 < DEPTH || popped) q.push_back(wd);
        else exp_ovf = 1;
      end
      answering = popped;
      tick();
      if (nxt_ready) exp_data = nxt_data;
      checks++; if (input_data_ready !== nxt_ready) begin failures++; $display("FAIL rand_ready[%0d]: got %b want %b", c, input_data_ready, nxt_ready); end
      checks++; if (input_data !== exp_data) begin failures++; $display("FAIL rand_data[%0d]: got %h want %h", c, input_data, exp_data); end
      checks++; if (count !== 3'(q.size())) begin failures++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, count, q.size()); end
      checks++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin failures++; $display("FAIL rand_flags[%0d]: got empty=%b full=%b want size %0d", c, empty, full, q.size()); end
      checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL rand_overflow[%0d]: got %b want %b", c, overflow, exp_ovf); end
    end
    we = 1'b0; req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wd = 32'h0; req = 1'b0;
    test_reset();
    test_order();
    test_wait_bypass();
    test_overflow();
    test_simul_full();
    test_wrap();
    test_reset_mid_wait();
    test_random(30, 50, 600);
    test_random(60, 30, 600);
    test_random(15, 70, 600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
